// File: rtl/sram_pio_pkg.sv
// Shared definitions for the sRam parallel I/O port: register map and
// edge-type encodings, also consumed by the driver header generator.
package sram_pio_pkg;

  // Word addresses of the slave register map.
  typedef enum logic [2:0] {
    PIO_DATA    = 3'd0,
    PIO_DIR     = 3'd1,
    PIO_IRQMASK = 3'd2,
    PIO_EDGECAP = 3'd3,
    PIO_OUTSET  = 3'd4,
    PIO_OUTCLR  = 3'd5,
    PIO_RSVD6   = 3'd6,
    PIO_RSVD7   = 3'd7
  } pio_addr_e;

  // Edge-type parameter encodings.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Bus data width of the Avalon-MM slave.
  localparam int BUS_W = 32;

endpackage : sram_pio_pkg

// File: rtl/pio_in_sync.sv
// Input conditioning for the PIO port: multi-stage synchroniser, previous
// value register, post-reset warm-up counter and gated rise/fall detection.
module pio_in_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Edges are ignored until the chain has filled and prev has caught up,
  // so pins already high at reset release do not look like rising edges.
  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W       = $clog2(WARM_CYCLES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] warm_cnt_q;
  logic             warm;

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign warm    = (warm_cnt_q == CNT_W'(WARM_CYCLES));

  // Synchroniser chain and previous-value register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the chain is an array but is still reset; a stale 1 left in it would fake an edge.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= in_sync;
    end
  end

  // Saturating warm-up counter, started by reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt_q <= '0;
    end else if (!warm) begin
      warm_cnt_q <= warm_cnt_q + 1'b1;
    end
  end

  assign rise = in_sync & ~prev_q & {WIDTH{warm}};
  assign fall = ~in_sync & prev_q & {WIDTH{warm}};

endmodule : pio_in_sync

// File: rtl/sram_pio_port.sv
// Avalon-MM parallel I/O port: per-bit direction, synchronised inputs,
// edge capture with write-1-to-clear, interrupt masking and atomic
// bit set/clear. Zero wait states, combinational readdata, registered irq.
module sram_pio_port
  import sram_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr;
  logic             irq_q;

  logic [WIDTH-1:0] in_sync, rise, fall, edge_sel;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  pio_addr_e        addr;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  assign addr  = pio_addr_e'(address);

  // Write-data bits above the port width are deliberately dropped.
  if (WIDTH < BUS_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[BUS_W-1:WIDTH];
  end

  pio_in_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .in_sync (in_sync),
    .rise    (rise),
    .fall    (fall)
  );

  // Select the configured edge type; output-direction bits never capture.
  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_sel = fall;
      EDGE_ANY:  edge_sel = rise | fall;
      default:   edge_sel = rise;
    endcase
    edge_sel = edge_sel & ~dir_q;
  end

  // Register-file write decode, including atomic set/clear and W1C.
  always_comb begin
    // NOTE: every variable gets its default first so no path infers a latch.
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    clr        = '0;
    if (wr_en) begin
      case (addr)
        PIO_DATA:    data_out_d = wdata;
        PIO_DIR:     dir_d      = wdata;
        PIO_IRQMASK: mask_d     = wdata;
        PIO_EDGECAP: clr        = wdata;
        PIO_OUTSET:  data_out_d = data_out_q | wdata;
        PIO_OUTCLR:  data_out_d = data_out_q & ~wdata;
        default:     ;
      endcase
    end
  end

  // A new edge wins over a simultaneous clear of the same bit.
  assign edgecap_d = (edgecap_q & ~clr) | edge_sel;

  // Control registers, edge capture and the registered interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= DIR_RESET;
      mask_q     <= '0;
      edgecap_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      irq_q      <= |(edgecap_q & mask_q);
    end
  end

  // Combinational read mux; unused upper bits and write-only words read 0.
  always_comb begin
    readdata = '0;
    case (addr)
      PIO_DATA:    readdata[WIDTH-1:0] = (dir_q & data_out_q) | (~dir_q & in_sync);
      PIO_DIR:     readdata[WIDTH-1:0] = dir_q;
      PIO_IRQMASK: readdata[WIDTH-1:0] = mask_q;
      PIO_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:     ;
    endcase
  end

  assign out_port = data_out_q;
  assign oe       = dir_q;
  assign irq      = irq_q;

endmodule : sram_pio_port

// File: tb/tb_sram_pio_port.sv
// Scoreboard bench for sram_pio_port (WIDTH=8, RESET_VALUE=A5, rising edge,
// two sync stages). Stimulus pushes expectations; a negedge monitor pops and
// compares them against the DUT.
module tb_sram_pio_port;

  localparam int SEL_RD  = 0;
  localparam int SEL_OUT = 1;
  localparam int SEL_OE  = 2;
  localparam int SEL_IRQ = 3;

  localparam logic [2:0] A_DATA = 3'd0, A_DIR = 3'd1, A_MASK = 3'd2, A_ECAP = 3'd3,
                         A_OSET = 3'd4, A_OCLR = 3'd5, A_RSV6 = 3'd6, A_RSV7 = 3'd7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp_val;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  exp_t sb[$];
  logic sample_en;
  int   checks   = 0;
  int   failures = 0;

  sram_pio_port #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .DIR_RESET   (8'hFF),
    .EDGE_TYPE   (0),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %08h want %08h", name, act, exp_v);
    end
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    if (sample_en) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          SEL_RD:  act = readdata;
          SEL_OUT: act = {24'h0, out_port};
          SEL_OE:  act = {24'h0, oe};
          default: act = {31'h0, irq};
        endcase
        check(e.name, act, e.exp_val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    sample_en  = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic expect_pin(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name    = name;
    e.sel     = sel;
    e.exp_val = v;
    sb.push_back(e);
    sample_en = 1'b1;
  endtask

  task automatic expect_rd(input string name, input logic [2:0] a, input logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    expect_pin(name, SEL_RD, v);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    sample_en  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;

    // Reset values
    expect_pin("rst_out_port", SEL_OUT, 32'hA5);
    expect_pin("rst_oe", SEL_OE, 32'hFF);
    expect_pin("rst_irq", SEL_IRQ, 32'h0);
    expect_rd("rst_rd_data", A_DATA, 32'h0000_00A5);
    tick();

    // Atomic set / clear
    bus_write(A_OSET, 32'h0F);
    expect_pin("outset_port", SEL_OUT, 32'hAF);
    expect_rd("outset_rd0", A_OSET, 32'h0);
    tick();
    bus_write(A_OCLR, 32'hFFFF_FF81);
    expect_pin("outclr_port", SEL_OUT, 32'h2E);
    expect_rd("outclr_rd0", A_OCLR, 32'h0);
    tick();

    // Reserved words: writes ignored, reads 0
    bus_write(A_RSV6, 32'hFF);
    expect_pin("rsv_port", SEL_OUT, 32'h2E);
    expect_pin("rsv_oe", SEL_OE, 32'hFF);
    expect_rd("rsv6_rd", A_RSV6, 32'h0);
    tick();
    expect_rd("rsv7_rd", A_RSV7, 32'h0);
    tick();

    // Mixed direction read-back through the synchroniser
    bus_write(A_DIR, 32'h0F);
    expect_pin("dir_oe", SEL_OE, 32'h0F);
    expect_rd("dir_rd", A_DIR, 32'h0F);
    tick();
    bus_write(A_DATA, 32'h3C);
    in_port = 8'hF0;
    tick();
    expect_rd("data_sync1", A_DATA, 32'h0C);
    tick();
    expect_rd("data_sync2", A_DATA, 32'hFC);
    tick();
    expect_rd("ecap_inputs", A_ECAP, 32'hF0);
    expect_pin("irq_masked", SEL_IRQ, 32'h0);
    tick();
    bus_write(A_ECAP, 32'hFF);
    expect_rd("ecap_w1c_all", A_ECAP, 32'h0);
    tick();

    // Rising edge capture and irq latency
    bus_write(A_DIR, 32'h0);
    in_port = 8'h00;
    repeat (4) tick();
    expect_rd("ecap_no_fall", A_ECAP, 32'h0);
    tick();
    bus_write(A_MASK, 32'h01);
    expect_rd("mask_rd", A_MASK, 32'h01);
    tick();
    in_port = 8'h01;
    tick();
    tick();
    expect_rd("ecap_plus2", A_ECAP, 32'h0);
    expect_pin("irq_plus2", SEL_IRQ, 32'h0);
    tick();
    expect_rd("ecap_plus3", A_ECAP, 32'h01);
    expect_pin("irq_plus3", SEL_IRQ, 32'h0);
    tick();
    expect_pin("irq_plus4", SEL_IRQ, 32'h1);
    bus_write(A_ECAP, 32'h01);
    expect_rd("ecap_cleared", A_ECAP, 32'h0);
    expect_pin("irq_clr_lag", SEL_IRQ, 32'h1);
    tick();
    expect_pin("irq_cleared", SEL_IRQ, 32'h0);
    tick();

    // Edge and W1C on the same bit in the same cycle: set wins
    in_port = 8'h00;
    repeat (4) tick();
    in_port = 8'h01;
    tick();
    tick();
    bus_write(A_ECAP, 32'h01);
    expect_rd("set_wins", A_ECAP, 32'h01);
    expect_pin("set_wins_irq0", SEL_IRQ, 32'h0);
    tick();
    expect_pin("set_wins_irq1", SEL_IRQ, 32'h1);
    bus_write(A_MASK, 32'h0);
    expect_pin("unmask_lag", SEL_IRQ, 32'h1);
    tick();
    expect_pin("unmask_irq0", SEL_IRQ, 32'h0);
    expect_rd("ecap_retained", A_ECAP, 32'h01);
    tick();

    // Asynchronous reset mid-operation with irq pending
    bus_write(A_MASK, 32'h01);
    bus_write(A_DATA, 32'h55);
    expect_pin("pre_rst_irq", SEL_IRQ, 32'h1);
    expect_pin("pre_rst_port", SEL_OUT, 32'h55);
    tick();
    reset_n = 1'b0;
    expect_pin("arst_irq", SEL_IRQ, 32'h0);
    expect_pin("arst_port", SEL_OUT, 32'hA5);
    expect_pin("arst_oe", SEL_OE, 32'hFF);
    expect_rd("arst_mask", A_MASK, 32'h0);
    tick();
    in_port = 8'hFF;
    expect_rd("arst_ecap", A_ECAP, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    expect_rd("no_spurious_ecap", A_ECAP, 32'h0);
    expect_pin("no_spurious_irq", SEL_IRQ, 32'h0);
    tick();
    expect_rd("post_rst_data", A_DATA, 32'hA5);
    tick();
    bus_write(A_DIR, 32'h0);
    expect_rd("input_read", A_DATA, 32'hFF);
    expect_pin("input_oe", SEL_OE, 32'h0);
    tick();
    tick();
    expect_rd("dir_switch_no_edge", A_ECAP, 32'h0);
    tick();

    check("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sram_pio_port
